// File: rtl/menu_pkg.sv
// menu_pkg: shared definitions for the configuration-menu controller.
//   - page codes as driven on menu_sel
//   - bit positions of each mode inside the one-hot modos vector
//   - controller state encoding
package menu_pkg;

  localparam int unsigned PageW = 3;

  localparam logic [PageW-1:0] PAGE_MODO   = 3'd0;
  localparam logic [PageW-1:0] PAGE_BPM    = 3'd1;
  localparam logic [PageW-1:0] PAGE_TOM    = 3'd2;
  localparam logic [PageW-1:0] PAGE_MUSICA = 3'd3;
  localparam logic [PageW-1:0] PAGE_ERRO   = 3'd4;
  localparam logic [PageW-1:0] PAGE_GRAVA  = 3'd5;

  localparam int unsigned MODE_FREE  = 0;  // free play
  localparam int unsigned MODE_LEARN = 1;  // learn
  localparam int unsigned MODE_REC   = 2;  // record
  localparam int unsigned MODE_PLAY  = 3;  // playback

  typedef enum logic [1:0] {
    StInit = 2'd0,
    StPage = 2'd1,
    StRun  = 2'd2
  } menu_state_e;

endpackage

// File: rtl/menu_path.sv
// menu_path: combinational page-sequence tables, one per mode.
//   modos      - one-hot mode vector (live value from the menu)
//   page       - current page code
//   next_page  - page reached by Enter (meaningless when is_last)
//   prev_page  - page reached by Back (meaningless when is_first)
//   is_last    - Enter on this page completes configuration
//   is_first   - page is MODO, Back does nothing
//   mode_valid - modos is exactly one-hot on a known mode bit
// A page that is not on the selected path falls back to MODO in both directions,
// which covers the mode being changed underneath an open path.
module menu_path
  import menu_pkg::*;
#(
  parameter int unsigned MODO = 4
) (
  input  logic [MODO-1:0]  modos,
  input  logic [PageW-1:0] page,
  output logic [PageW-1:0] next_page,
  output logic [PageW-1:0] prev_page,
  output logic             is_last,
  output logic             is_first,
  output logic             mode_valid
);

  assign mode_valid = $onehot(modos) && (|modos[3:0]);
  assign is_first   = (page == PAGE_MODO);

  always_comb begin
    next_page = PAGE_MODO;
    prev_page = PAGE_MODO;
    is_last   = 1'b0;
    if (mode_valid) begin
      if (modos[MODE_FREE]) begin
        // MODO -> TOM -> RUN
        case (page)
          PAGE_MODO: next_page = PAGE_TOM;
          PAGE_TOM:  begin is_last = 1'b1; next_page = page; prev_page = PAGE_MODO; end
          default:   ;
        endcase
      end else if (modos[MODE_LEARN]) begin
        // MODO -> BPM -> TOM -> MUSICA -> ERRO -> RUN
        case (page)
          PAGE_MODO:   next_page = PAGE_BPM;
          PAGE_BPM:    begin next_page = PAGE_TOM;    prev_page = PAGE_MODO;   end
          PAGE_TOM:    begin next_page = PAGE_MUSICA; prev_page = PAGE_BPM;    end
          PAGE_MUSICA: begin next_page = PAGE_ERRO;   prev_page = PAGE_TOM;    end
          PAGE_ERRO:   begin is_last = 1'b1; next_page = page; prev_page = PAGE_MUSICA; end
          default:     ;
        endcase
      end else if (modos[MODE_REC]) begin
        // MODO -> BPM -> TOM -> GRAVA -> RUN
        case (page)
          PAGE_MODO:  next_page = PAGE_BPM;
          PAGE_BPM:   begin next_page = PAGE_TOM;   prev_page = PAGE_MODO; end
          PAGE_TOM:   begin next_page = PAGE_GRAVA; prev_page = PAGE_BPM;  end
          PAGE_GRAVA: begin is_last = 1'b1; next_page = page; prev_page = PAGE_TOM; end
          default:    ;
        endcase
      end else begin
        // MODE_PLAY: MODO -> MUSICA -> BPM -> RUN
        case (page)
          PAGE_MODO:   next_page = PAGE_MUSICA;
          PAGE_MUSICA: begin next_page = PAGE_BPM; prev_page = PAGE_MODO; end
          PAGE_BPM:    begin is_last = 1'b1; next_page = page; prev_page = PAGE_MUSICA; end
          default:     ;
        endcase
      end
    end
  end

endmodule

// File: rtl/menu_controller.sv
// menu_controller: sequences the configuration menu pages with Enter/Back, gates
// the arrow keys to open pages only, and issues start when configuration ends.
//   clock, reset           - system clock, synchronous active-high reset
//   enter_pressed, back_pressed - key levels, edge-detected internally
//   right_arrow_i, left_arrow_i - raw arrow levels
//   modos                  - one-hot mode read back from the menu
//   game_end               - pulse from the game core, returns to MODO
//   menu_sel               - page select to the menu (0 outside PAGE)
//   load_initial           - one-cycle reload of menu defaults after reset
//   right_arrow_o, left_arrow_o - arrows gated by PAGE state (combinational)
//   page_changed           - pulse whenever a page is (re)entered
//   config_done            - high while in RUN
//   start                  - pulse on entering RUN
module menu_controller
  import menu_pkg::*;
#(
  parameter int unsigned MODO = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            enter_pressed,
  input  logic            back_pressed,
  input  logic            right_arrow_i,
  input  logic            left_arrow_i,
  input  logic [MODO-1:0] modos,
  input  logic            game_end,
  output logic [2:0]      menu_sel,
  output logic            load_initial,
  output logic            right_arrow_o,
  output logic            left_arrow_o,
  output logic            page_changed,
  output logic            config_done,
  output logic            start
);

  menu_state_e      state_q;
  logic [PageW-1:0] page_q;
  logic [2:0]       menu_sel_q;
  logic             load_initial_q;
  logic             page_changed_q;
  logic             config_done_q;
  logic             start_q;
  logic             enter_prev_q;
  logic             back_prev_q;

  logic             enter_pulse;
  logic             back_pulse;
  logic [PageW-1:0] next_page;
  logic [PageW-1:0] prev_page;
  logic             is_last;
  logic             is_first;
  logic             mode_valid;

  assign enter_pulse = enter_pressed & ~enter_prev_q;
  assign back_pulse  = back_pressed & ~back_prev_q;

  menu_path #(
    .MODO(MODO)
  ) u_path (
    .modos     (modos),
    .page      (page_q),
    .next_page (next_page),
    .prev_page (prev_page),
    .is_last   (is_last),
    .is_first  (is_first),
    .mode_valid(mode_valid)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= StInit;
      page_q         <= PAGE_MODO;
      menu_sel_q     <= PAGE_MODO;
      load_initial_q <= 1'b1;
      page_changed_q <= 1'b0;
      config_done_q  <= 1'b0;
      start_q        <= 1'b0;
      // Preset high so a key held through reset needs a release before it acts.
      enter_prev_q   <= 1'b1;
      back_prev_q    <= 1'b1;
    end else begin
      enter_prev_q   <= enter_pressed;
      back_prev_q    <= back_pressed;
      load_initial_q <= 1'b0;
      page_changed_q <= 1'b0;
      start_q        <= 1'b0;
      case (state_q)
        StInit: begin
          state_q        <= StPage;
          page_q         <= PAGE_MODO;
          menu_sel_q     <= PAGE_MODO;
          page_changed_q <= 1'b1;
        end
        StPage: begin
          // Simultaneous Enter and Back cancel each other.
          if (enter_pulse && !back_pulse) begin
            if (mode_valid) begin
              if (is_last) begin
                state_q       <= StRun;
                page_q        <= PAGE_MODO;
                menu_sel_q    <= PAGE_MODO;
                config_done_q <= 1'b1;
                start_q       <= 1'b1;
              end else begin
                page_q         <= next_page;
                menu_sel_q     <= next_page;
                page_changed_q <= 1'b1;
              end
            end
          end else if (back_pulse && !enter_pulse && !is_first) begin
            page_q         <= prev_page;
            menu_sel_q     <= prev_page;
            page_changed_q <= 1'b1;
          end
        end
        StRun: begin
          // No reload here: selections made on the pages are kept.
          if (game_end) begin
            state_q        <= StPage;
            page_q         <= PAGE_MODO;
            menu_sel_q     <= PAGE_MODO;
            config_done_q  <= 1'b0;
            page_changed_q <= 1'b1;
          end
        end
        default: begin
          state_q        <= StInit;
          load_initial_q <= 1'b1;
        end
      endcase
    end
  end

  assign menu_sel      = menu_sel_q;
  assign load_initial  = load_initial_q;
  assign page_changed  = page_changed_q;
  assign config_done   = config_done_q;
  assign start         = start_q;
  assign right_arrow_o = right_arrow_i & (state_q == StPage);
  assign left_arrow_o  = left_arrow_i & (state_q == StPage);

endmodule

// File: doc/menu_controller.md
# menu_controller

Sequencing controller for the configuration menu. It drives the menu's `menu_sel` and `load_initial`, gates the left/right arrow levels so the menu shift registers only move while a page is open, and walks the user through a mode-dependent page sequence using Enter/Back keys. It sits between the keyboard front end and the menu block, and hands a `start` pulse to the game core when configuration is complete.

## Interface

**Parameters**
- `MODO`, default 4: width of the one-hot mode vector read back from the menu.

**Ports**
- `clock`, input, 1: system clock.
- `reset`, input, 1: synchronous, active-high.
- `enter_pressed`, input, 1: Enter key level, already synchronous.
- `back_pressed`, input, 1: Back key level, already synchronous.
- `right_arrow_i`, input, 1: right-arrow key level.
- `left_arrow_i`, input, 1: left-arrow key level.
- `modos`, input, MODO: one-hot mode from the menu.
- `game_end`, input, 1: one-cycle pulse from the game core.
- `menu_sel`, output, 3: page select driven to the menu.
- `load_initial`, output, 1: loads the menu registers to their defaults.
- `right_arrow_o`, output, 1: gated arrow level.
- `left_arrow_o`, output, 1: gated arrow level.
- `page_changed`, output, 1: one-cycle pulse when `menu_sel` takes a new value; used for the Arduino display refresh.
- `config_done`, output, 1: high while the game runs.
- `start`, output, 1: one-cycle pulse on entering RUN.

## Operation

**States:** INIT, PAGE, RUN. A registered `page` field holds the current page code.

**Page codes**
- 0 = MODO
- 1 = BPM
- 2 = TOM
- 3 = MUSICA
- 4 = ERRO
- 5 = GRAVA

**Paths, selected by the `modos` bit**
- bit0 (free play): MODO → TOM → RUN
- bit1 (learn): MODO → BPM → TOM → MUSICA → ERRO → RUN
- bit2 (record): MODO → BPM → TOM → GRAVA → RUN
- bit3 (playback): MODO → MUSICA → BPM → RUN

**Edge detection**
- Per key: `prev` register; `pulse = level & ~prev`.
- Enter and Back use this detector.

**Transitions**
- INIT: `load_initial = 1`; next state is PAGE, page = MODO.
- PAGE, enter pulse alone: page ← next(mode, page); at the end of the path go to RUN.
- PAGE, back pulse alone: page ← prev(mode, page). Back on MODO is ignored.
- PAGE, enter and back pulses in the same cycle: both ignored.
- Enter on MODO with `modos` not exactly one-hot: ignored, stay on MODO.
- RUN, `game_end`: go to PAGE, page = MODO. No reload, so selections are kept.
- RUN: Enter and Back are ignored.
- `reset` overrides everything: state INIT.

**Outputs**
- `menu_sel = page` in PAGE.
- `menu_sel = 0` in INIT and RUN.
- Arrow outputs: `right_arrow_o = right_arrow_i & (state == PAGE)`, and likewise for left. Combinational from the registered state. Both are 0 in INIT and RUN.
- `config_done = (state == RUN)`.
- The mode used by the path is the live `modos` value, read at each transition.

## Timing

**Reset values (during and immediately after `reset`)**
- state INIT, `load_initial = 1`, `menu_sel = 0`.
- `page_changed = 0`, `config_done = 0`, `start = 0`.
- Arrows out 0; `prev` registers = 1, so a key held through reset does not fire.

**Load and first page**
- `load_initial` is high for exactly one cycle: the first cycle after `reset` falls.
- The next cycle is PAGE/MODO with `page_changed = 1`.

**Key latency**
- A key level first seen high at edge N: the new `menu_sel` and `page_changed` appear after edge N.
- Holding a key produces exactly one action.
- Consecutive presses need at least one low cycle between them.

**Start**
- `start` and `config_done` rise together in the first RUN cycle.
- `start` is high for one cycle only.

**Game end**
- `game_end` in RUN: PAGE/MODO from the next cycle, with `page_changed = 1`.

**Other rules**
- `page_changed` fires only on an actual page change, including a re-entry from RUN. It stays 0 for ignored keys.
- All outputs are registered except the gated arrows.

## Structure

**Shared package `menu_pkg`**
- Page code constants `PAGE_MODO` .. `PAGE_GRAVA`.
- Mode bit indices.
- State enum for INIT, PAGE and RUN.

**Sub-module `menu_path`**
- Combinational.
- Inputs: `modos`, `page`.
- Outputs: `next_page`, `prev_page`, `is_last`, `is_first`, `mode_valid`.
- Isolates the path tables, so adding a mode touches only this sub-module.

The key edge detectors are internal.

## Test plan

- Release `reset` → `load_initial` high exactly 1 cycle; next cycle `menu_sel = 0`, `page_changed = 1`; arrows gated low during INIT.
- `modos = 4'b0010`, Enter ×4 → `menu_sel` sequence 1, 2, 3, 4; 5th Enter → `start` for 1 cycle, `config_done = 1`, `menu_sel = 0`, arrows gated.
- `modos = 4'b0100`, Enter to GRAVA (5), then Back ×3 → 2, 1, 0; 4th Back ignored, `page_changed = 0`.
- Enter held 10 cycles → single advance. Enter and Back rising in the same cycle → no change.
- `modos = 4'b0000` or `4'b0011`, Enter on MODO → stays at 0, no `page_changed`. `modos = 4'b1000` → path 3, 1, RUN.
- In RUN, pulse `game_end` → `menu_sel = 0`, `config_done = 0`, no `load_initial`. Assert `reset` mid-path (page 3) → INIT, then reload pulse.
